bicubic_upsample_mc: RTL and testbench
======================================

# bicubic_upsample_mc

Parametrised ×4 bicubic upsampler core for multi-channel pixels. It accepts one 4×4 source window per handshake and performs a vertical pass, then a horizontal pass. Each window produces four horizontally adjacent output pixels for every channel. It sits between the line-buffer (`bf_*`) and access control (`bcci_*`), replacing the single-channel core. It adds a parameter-controlled pipeline depth, input-side phase tagging carried through the pipeline, and end-of-line/end-of-frame flags.

## Interface
- `CHANNEL_WIDTH`, 8: bits per channel sample.
- `CHANNEL_NUM`, 3: channels per pixel.
- `BLOCK_SIZE`, 960: windows per output row.
- `SRC_IMG_HEIGHT`, 540: source rows; output rows = 4×this.
- `PIPE_STAGES`, 3: pipeline depth, legal range 2..6.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `bf_req_valid` in 1: window valid.
- `bcci_req_ready` out 1: window accepted.
- `bf_req_data` in CHANNEL_NUM×16×CHANNEL_WIDTH: sample (row r, col c, channel ch) at bits `[((ch*16)+4r+c)*CHANNEL_WIDTH +: CHANNEL_WIDTH]`.
- `bcci_rsp_valid` out 1: output valid.
- `bf_rsp_ready` in 1: downstream ready.
- `bcci_rsp_data` out CHANNEL_NUM×4×CHANNEL_WIDTH: lane k of channel ch at bits `[((ch*4)+k)*CHANNEL_WIDTH +: CHANNEL_WIDTH]`.
- `bcci_rsp_eol` out 1: last output of an output row; qualified by `bcci_rsp_valid`.
- `bcci_rsp_eof` out 1: last output of the frame; qualified by `bcci_rsp_valid`.

## Operation
**Weights** are signed Q11 and each set sums to 2048.
- u=1/8: (-147, 1981, 235, -21)
- u=3/8: (-225, 1535, 873, -135)
- u=5/8: (-135, 873, 1535, -225)
- u=7/8: (-21, 235, 1981, -147)

**Phase FSM** sits on the input side and advances on the last window of each output row.
- States: S1(5/8) → S2(7/8) → S3(1/8) → S4(3/8) → S1.
- Reset state: S1.

**Counters** advance on the input handshake.
- Column counter runs 0..BLOCK_SIZE-1 and wraps to 0.
- Row counter runs 0..4×SRC_IMG_HEIGHT-1 and wraps to 0 at frame end. The FSM also returns to S1 at frame end.
- The window's phase, an eol bit (column counter = BLOCK_SIZE-1) and an eof bit (eol and row counter = last row) are captured with the window and travel down the pipeline.

**Vertical pass**, per channel and column c:
- Sum over r of {1'b0, pixel} × vertical-phase weight.
- Signed result width: CHANNEL_WIDTH+14.

**Horizontal pass**: lane k uses phase 1/8, 3/8, 5/8, 7/8 for k = 0..3. Signed result width: CHANNEL_WIDTH+28; scale 2^22.

**Output**:
- Negative result → 0.
- Result ≥ 2^CHANNEL_WIDTH after shift → all ones.
- Otherwise output bits [CHANNEL_WIDTH+21:22].

## Timing
- Global-stall pipeline:
  - `pipe_en = ~bcci_rsp_valid | bf_rsp_ready`.
  - `bcci_req_ready = pipe_en`.
  - Every stage register, including the per-stage valid bits, loads only when `pipe_en` is high.
- Latency is exactly PIPE_STAGES cycles from input handshake to `bcci_rsp_valid` when no stall occurs. Throughput is 1 window per cycle.
- Bubbles (`bf_req_valid` low) propagate as invalid stages; they do not advance the counters or the FSM.
- While `bcci_rsp_valid` is high and `bf_rsp_ready` is low, `bcci_rsp_data`, `bcci_rsp_eol` and `bcci_rsp_eof` stay stable.
- Reset values:
  - All valid bits, counters, `bcci_rsp_valid`, `bcci_rsp_eol` and `bcci_rsp_eof` are 0.
  - FSM is S1.
  - `bcci_rsp_data` is 0; datapath registers may be non-reset but must be masked to 0 while invalid.
- Reset mid-operation: all in-flight windows are discarded. The next accepted window is treated as row 0, column 0, phase S1.
- When an eol and an eof window are accepted in the same handshake, the counter wrap and the FSM return to S1 occur together.

## Configuration
- `BICUBIC_ROUND_EN` defined: add 2^21 to the horizontal result before the shift and clamp (round half up).
- `BICUBIC_ROUND_EN` undefined: truncate.
- Latency and widths are identical in both builds.

## Test plan
- **Constant window**: all samples 100 on all channels, continuous valid, ready=1 → every lane = 100. First valid output appears exactly PIPE_STAGES cycles after the first handshake.
- **Horizontal ramp**: rows identical, columns (0, 0, 255, 255).
  - Lanes = 26, 91, 163, 228 with `BICUBIC_ROUND_EN` undefined.
  - Lanes = 27, 92, 163, 228 with it defined.
- **Clamping**: columns (255, 0, 0, 0) → lane 0 = 0. Columns (0, 255, 255, 255) → lane 0 = 255.
- **Backpressure**: hold `bf_rsp_ready` low for 5 cycles with valid output → `bcci_req_ready` low, output data and flags stable, and no windows lost or duplicated after release.
- **Counters** with BLOCK_SIZE=4, SRC_IMG_HEIGHT=2 and 32 windows (random valid gaps):
  - `bcci_rsp_eol` on outputs 4, 8, …, 32.
  - `bcci_rsp_eof` only on output 32.
  - Row phase sequence 5/8, 7/8, 1/8, 3/8, repeated; window 33 uses phase 5/8.
- **Mid-frame reset**: assert `rst_n` low after window 10 → outputs drop to 0 asynchronously. After release, the first window is processed with phase 5/8 and eol occurs after BLOCK_SIZE windows.

Source files
------------

// File: rtl/bicubic_upsample_mc.sv
// x4 bicubic upsampler for multi-channel pixels: input phase/eol/eof tagging, vertical then horizontal pass, global-stall pipeline.
// Optional round-half-up on the horizontal result when BICUBIC_ROUND_EN is defined; truncation otherwise.
module bicubic_upsample_mc #(
  parameter int unsigned CHANNEL_WIDTH  = 8,
  parameter int unsigned CHANNEL_NUM    = 3,
  parameter int unsigned BLOCK_SIZE     = 960,
  parameter int unsigned SRC_IMG_HEIGHT = 540,
  parameter int unsigned PIPE_STAGES    = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   bf_req_valid,
  output logic                                   bcci_req_ready,
  input  logic [CHANNEL_NUM*16*CHANNEL_WIDTH-1:0] bf_req_data,
  output logic                                   bcci_rsp_valid,
  input  logic                                   bf_rsp_ready,
  output logic [CHANNEL_NUM*4*CHANNEL_WIDTH-1:0]  bcci_rsp_data,
  output logic                                   bcci_rsp_eol,
  output logic                                   bcci_rsp_eof
);
  localparam int unsigned CW    = CHANNEL_WIDTH;
  localparam int unsigned IN_W  = CHANNEL_NUM * 16 * CW;
  localparam int unsigned OUT_W = CHANNEL_NUM * 4 * CW;
  localparam int unsigned WT_W  = 12;
  localparam int unsigned VW    = CW + 14;
  localparam int unsigned HW    = CW + 28;
  localparam int unsigned ROWS  = 4 * SRC_IMG_HEIGHT;
  localparam int unsigned COL_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DLY   = PIPE_STAGES - 1;

  // Phase code doubles as the weight-table row: 0=1/8, 1=3/8, 2=5/8, 3=7/8.
  localparam logic signed [WT_W-1:0] W_TAB [4][4] = '{
    '{-12'sd147, 12'sd1981, 12'sd235,  -12'sd21},
    '{-12'sd225, 12'sd1535, 12'sd873,  -12'sd135},
    '{-12'sd135, 12'sd873,  12'sd1535, -12'sd225},
    '{-12'sd21,  12'sd235,  12'sd1981, -12'sd147}
  };

`ifdef BICUBIC_ROUND_EN
  localparam logic signed [HW-1:0] RND = HW'(2**21);
`else
  localparam logic signed [HW-1:0] RND = HW'(0);
`endif

  typedef enum logic [1:0] {S1, S2, S3, S4} phase_state_e;

  phase_state_e      state, state_nxt;
  logic [1:0]        v_phase_c;
  logic              pipe_en, hs, at_eol, at_eof;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;

  logic              s1_valid, s1_eol, s1_eof;
  logic [1:0]        s1_phase;
  logic [IN_W-1:0]   s1_win;
  logic [OUT_W-1:0]  res_c;

  logic [OUT_W-1:0]  dl_data  [DLY];
  logic              dl_valid [DLY];
  logic              dl_eol   [DLY];
  logic              dl_eof   [DLY];

  assign pipe_en        = ~bcci_rsp_valid | bf_rsp_ready;
  assign bcci_req_ready = pipe_en;
  assign hs             = bf_req_valid & pipe_en;
  assign at_eol         = (col_cnt == COL_W'(BLOCK_SIZE - 1));
  assign at_eof         = at_eol & (row_cnt == ROW_W'(ROWS - 1));

  // Row-phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S1;
    else        state <= state_nxt;
  end

  // Advance on the last window of a row; frame end forces S1
  always_comb begin
    state_nxt = state;
    if (hs && at_eof) begin
      state_nxt = S1;
    end else if (hs && at_eol) begin
      case (state)
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = S4;
        default: state_nxt = S1;
      endcase
    end
  end

  always_comb begin
    v_phase_c = 2'd2;
    case (state)
      S1:      v_phase_c = 2'd2;
      S2:      v_phase_c = 2'd3;
      S3:      v_phase_c = 2'd0;
      default: v_phase_c = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (hs) begin
      if (at_eol) begin
        col_cnt <= '0;
        row_cnt <= at_eof ? '0 : row_cnt + ROW_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  // Input stage: window plus the tags it carries down the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_win   <= '0;
      s1_phase <= '0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (pipe_en) begin
      s1_valid <= bf_req_valid;
      s1_win   <= bf_req_data;
      s1_phase <= v_phase_c;
      s1_eol   <= hs & at_eol;
      s1_eof   <= hs & at_eof;
    end
  end

  // Vertical pass per column, horizontal pass per lane, then clamp
  always_comb begin
    logic signed [VW-1:0] vacc;
    logic signed [HW-1:0] hacc;
    logic signed [VW-1:0] vcol [4];
    logic [CW-1:0]        lane;
    res_c = '0;
    for (int ch = 0; ch < int'(CHANNEL_NUM); ch++) begin
      for (int c = 0; c < 4; c++) begin
        vacc = '0;
        for (int r = 0; r < 4; r++) begin
          vacc = vacc + VW'($signed({1'b0, s1_win[((ch*16)+4*r+c)*CW +: CW]}))
                      * VW'(W_TAB[s1_phase][2'(r)]);
        end
        vcol[c] = vacc;
      end
      for (int k = 0; k < 4; k++) begin
        hacc = RND;
        for (int c = 0; c < 4; c++) begin
          hacc = hacc + HW'(vcol[c]) * HW'(W_TAB[2'(k)][2'(c)]);
        end
        if (hacc[HW-1])                lane = '0;
        else if (|hacc[HW-2:CW+22])    lane = '1;
        else                           lane = hacc[CW+21:22];
        res_c[((ch*4)+k)*CW +: CW] = lane;
      end
    end
    if (!s1_valid) res_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DLY); i++) begin
        dl_data[i]  <= '0;
        dl_valid[i] <= 1'b0;
        dl_eol[i]   <= 1'b0;
        dl_eof[i]   <= 1'b0;
      end
    end else if (pipe_en) begin
      dl_data[0]  <= res_c;
      dl_valid[0] <= s1_valid;
      dl_eol[0]   <= s1_eol;
      dl_eof[0]   <= s1_eof;
      for (int i = 1; i < int'(DLY); i++) begin
        dl_data[i]  <= dl_data[i-1];
        dl_valid[i] <= dl_valid[i-1];
        dl_eol[i]   <= dl_eol[i-1];
        dl_eof[i]   <= dl_eof[i-1];
      end
    end
  end

  assign bcci_rsp_valid = dl_valid[DLY-1];
  assign bcci_rsp_data  = dl_data[DLY-1];
  assign bcci_rsp_eol   = dl_eol[DLY-1];
  assign bcci_rsp_eof   = dl_eof[DLY-1];
endmodule

// File: tb/tb_bicubic_upsample_mc.sv
// Self-checking bench for bicubic_upsample_mc: directed steps with random data against an arithmetic reference model.
module tb_bicubic_upsample_mc;
  localparam int CW    = 8;
  localparam int CN    = 3;
  localparam int BS    = 4;
  localparam int SH    = 2;
  localparam int PS    = 3;
  localparam int ROWS  = 4 * SH;
  localparam int IN_W  = CN * 16 * CW;
  localparam int OUT_W = CN * 4 * CW;

  localparam int WT [4][4] = '{'{-147, 1981, 235, -21}, '{-225, 1535, 873, -135},
                               '{-135, 873, 1535, -225}, '{-21, 235, 1981, -147}};
  localparam int PH_SEQ [4] = '{2, 3, 0, 1};

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             eol;
    logic             eof;
    int               hs_tick;
    int               hs_stall;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bf_req_valid = 1'b0;
  logic             bcci_req_ready;
  logic [IN_W-1:0]  bf_req_data = '0;
  logic             bcci_rsp_valid;
  logic             bf_rsp_ready = 1'b1;
  logic [OUT_W-1:0] bcci_rsp_data;
  logic             bcci_rsp_eol;
  logic             bcci_rsp_eof;

  int checks = 0, errors = 0;
  int tick_n = 0, stall_cnt = 0, widx = 0, n_acc = 0;
  int nout = 0, eol_cnt = 0, eof_cnt = 0, eof_idx = 0, first_eol = 0;
  bit stalled_prev = 0;
  logic [OUT_W-1:0] hold_data, last_out;
  logic hold_eol, hold_eof;
  exp_t q[$];
  int ramp_exp[4];

  bicubic_upsample_mc #(
    .CHANNEL_WIDTH(CW), .CHANNEL_NUM(CN), .BLOCK_SIZE(BS),
    .SRC_IMG_HEIGHT(SH), .PIPE_STAGES(PS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready),
    .bf_req_data(bf_req_data), .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
    .bcci_rsp_data(bcci_rsp_data), .bcci_rsp_eol(bcci_rsp_eol), .bcci_rsp_eof(bcci_rsp_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain-integer bicubic on the frame position of this window
  function automatic exp_t model(input logic [IN_W-1:0] win, input int idx);
    exp_t e;
    int row, col, vph;
    longint v, h;
    row = (idx / BS) % ROWS;
    col = idx % BS;
    vph = PH_SEQ[row % 4];
    e.eol = (col == BS - 1);
    e.eof = e.eol && (row == ROWS - 1);
    e.data = '0;
    for (int ch = 0; ch < CN; ch++) begin
      for (int k = 0; k < 4; k++) begin
        h = 0;
        for (int c = 0; c < 4; c++) begin
          v = 0;
          for (int r = 0; r < 4; r++)
            v += longint'(int'(win[((ch*16)+4*r+c)*CW +: CW])) * WT[vph][r];
          h += v * WT[k][c];
        end
`ifdef BICUBIC_ROUND_EN
        h += 2097152;
`endif
        if (h < 0) h = 0;
        else begin
          h = h / 4194304;
          if (h > 255) h = 255;
        end
        e.data[((ch*4)+k)*CW +: CW] = CW'(h);
      end
    end
    e.hs_tick = 0;
    e.hs_stall = 0;
    return e;
  endfunction

  function automatic logic [IN_W-1:0] win_cols(input int c0, input int c1, input int c2, input int c3);
    logic [IN_W-1:0] w;
    int cols[4];
    cols = '{c0, c1, c2, c3};
    w = '0;
    for (int ch = 0; ch < CN; ch++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          w[((ch*16)+4*r+c)*CW +: CW] = CW'(cols[c]);
    return w;
  endfunction

  function automatic logic [IN_W-1:0] win_rand();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // One clock: evaluate stall/transfer/handshake at negedge+1, then advance
  task automatic tick();
    exp_t e;
    #1;
    if (bcci_rsp_valid && !bf_rsp_ready) begin
      chk("req_ready_stall", 128'(bcci_req_ready), 128'd0);
      if (stalled_prev) begin
        chk("hold_data", 128'(bcci_rsp_data), 128'(hold_data));
        chk("hold_flags", 128'({bcci_rsp_eol, bcci_rsp_eof}), 128'({hold_eol, hold_eof}));
      end
      hold_data = bcci_rsp_data;
      hold_eol = bcci_rsp_eol;
      hold_eof = bcci_rsp_eof;
      stalled_prev = 1;
      stall_cnt++;
    end else begin
      stalled_prev = 0;
    end
    if (!bcci_rsp_valid) chk("idle_data", 128'(bcci_rsp_data), 128'd0);
    if (bcci_rsp_valid && bf_rsp_ready) begin
      chk("out_expected", 128'(q.size() != 0), 128'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_data", 128'(bcci_rsp_data), 128'(e.data));
        chk("rsp_eol", 128'(bcci_rsp_eol), 128'(e.eol));
        chk("rsp_eof", 128'(bcci_rsp_eof), 128'(e.eof));
        chk("latency", 128'(tick_n - e.hs_tick), 128'(PS + stall_cnt - e.hs_stall));
        last_out = bcci_rsp_data;
        nout++;
        if (bcci_rsp_eol && nout <= 32) eol_cnt++;
        if (bcci_rsp_eol && first_eol == 0) first_eol = nout;
        if (bcci_rsp_eof) begin eof_cnt++; eof_idx = nout; end
      end
    end
    if (bf_req_valid && bcci_req_ready) begin
      e = model(bf_req_data, widx);
      e.hs_tick = tick_n;
      e.hs_stall = stall_cnt;
      q.push_back(e);
      widx = (widx + 1) % (BS * ROWS);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    tick_n++;
  endtask

  task automatic drain();
    int n;
    bf_req_valid = 1'b0;
    bf_rsp_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  task automatic do_reset();
    bf_req_valid = 1'b0;
    bf_rsp_ready = 1'b1;
    rst_n = 1'b0;
    q.delete();
    widx = 0;
    stalled_prev = 0;
    nout = 0; eol_cnt = 0; eof_cnt = 0; eof_idx = 0; first_eol = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef BICUBIC_ROUND_EN
    ramp_exp = '{27, 92, 163, 228};
`else
    ramp_exp = '{26, 91, 163, 228};
`endif
    // Reset state
    #1;
    chk("rst_valid", 128'(bcci_rsp_valid), 128'd0);
    chk("rst_data", 128'(bcci_rsp_data), 128'd0);
    chk("rst_flags", 128'({bcci_rsp_eol, bcci_rsp_eof}), 128'd0);
    do_reset();
    chk("rst_req_ready", 128'(bcci_req_ready), 128'd1);

    // Constant window, continuous valid
    bf_req_data = win_cols(100, 100, 100, 100);
    bf_req_valid = 1'b1;
    repeat (6) tick();
    drain();
    for (int i = 0; i < CN * 4; i++) chk("const_lane", 128'(last_out[i*CW +: CW]), 128'd100);

    // Horizontal ramp
    bf_req_data = win_cols(0, 0, 255, 255);
    bf_req_valid = 1'b1;
    tick();
    drain();
    for (int ch = 0; ch < CN; ch++)
      for (int k = 0; k < 4; k++)
        chk("ramp_lane", 128'(last_out[((ch*4)+k)*CW +: CW]), 128'(ramp_exp[k]));

    // Clamping low and high
    bf_req_data = win_cols(255, 0, 0, 0);
    bf_req_valid = 1'b1;
    tick();
    drain();
    for (int ch = 0; ch < CN; ch++) chk("clamp_low", 128'(last_out[(ch*4)*CW +: CW]), 128'd0);
    bf_req_data = win_cols(0, 255, 255, 255);
    bf_req_valid = 1'b1;
    tick();
    drain();
    for (int ch = 0; ch < CN; ch++) chk("clamp_high", 128'(last_out[(ch*4)*CW +: CW]), 128'd255);

    // Backpressure: ready low for 5 cycles while output is valid
    for (int t = 0; t < 14; t++) begin
      bf_rsp_ready = !(t >= 4 && t < 9);
      bf_req_valid = (t < 10);
      bf_req_data = win_rand();
      tick();
    end
    drain();

    // Counters and phases over a frame plus one row, random gaps
    do_reset();
    n_acc = 0;
    for (int t = 0; t < 400 && n_acc < 40; t++) begin
      bf_req_valid = ($urandom_range(0, 3) != 0);
      bf_rsp_ready = ($urandom_range(0, 4) != 0);
      bf_req_data = win_rand();
      tick();
    end
    chk("frame_accepted", 128'(n_acc), 128'd40);
    drain();
    chk("eol_count", 128'(eol_cnt), 128'd8);
    chk("eof_count", 128'(eof_cnt), 128'd1);
    chk("eof_index", 128'(eof_idx), 128'd32);

    // Mid-frame reset after 10 windows
    do_reset();
    n_acc = 0;
    bf_req_valid = 1'b1;
    while (n_acc < 10) begin bf_req_data = win_rand(); tick(); end
    bf_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bcci_rsp_valid), 128'd0);
    chk("mid_rst_data", 128'(bcci_rsp_data), 128'd0);
    chk("mid_rst_flags", 128'({bcci_rsp_eol, bcci_rsp_eof}), 128'd0);
    do_reset();
    bf_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bf_req_data = (i == 0) ? win_rand() : win_rand();
      tick();
    end
    drain();
    chk("post_rst_first_eol", 128'(first_eol), 128'(BS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
